// File: rtl/if_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : if_fetch
//  Purpose  : Instruction-fetch stage. Owns the fetch PC, issues in-order reads
//             on the instruction-memory req/gnt/rvalid interface, buffers the
//             returned words as {pc, inst} pairs and hands them to decode via
//             a valid/ready handshake. A flush redirects fetch and squashes
//             every instruction that is buffered or still in flight.
//  Ports    :
//    clk, rst                  clock (rising edge), async active-high reset
//    flush_i, flush_pc_i       redirect request and new fetch PC
//    imem_req_o, imem_addr_o   read request and word-aligned address
//    imem_gnt_i                request accepted this cycle
//    imem_rvalid_i/rdata_i     in-order read response
//    id_ready_i                decode accepts the presented pair
//    inst_valid_o, pc_o, inst_o  presented pair (pc/inst are 0 when empty)
//  Revision : 1.0  initial release
// ============================================================================
module if_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        id_ready_i,
  output logic        inst_valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W:0] c_DEPTH = (c_CNT_W + 1)'(FIFO_DEPTH);

  logic [31:0]        r_fetch_pc;
  logic [31:0]        r_resp_pc;
  logic [c_CNT_W-1:0] r_outstanding;
  logic [c_CNT_W-1:0] r_discard;
  logic [c_CNT_W-1:0] r_count;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [31:0]        r_fifo_pc   [FIFO_DEPTH];
  logic [31:0]        r_fifo_inst [FIFO_DEPTH];

  logic               w_credit;
  logic               w_issue;
  logic               w_ret;
  logic               w_has_discard;
  logic               w_push;
  logic               w_pop;
  logic               w_not_empty;
  logic [c_CNT_W-1:0] w_out_after_ret;
  logic [31:0]        w_flush_pc;

  // A request is only made when every word already in flight plus every word
  // buffered still leaves a free FIFO slot, so a response can always be pushed.
  assign w_credit      = ({1'b0, r_outstanding} + {1'b0, r_count}) < c_DEPTH;
  assign imem_req_o    = ~rst & ~flush_i & w_credit;
  assign imem_addr_o   = r_fetch_pc;
  assign w_issue       = imem_req_o & imem_gnt_i;

  // Responses with nothing outstanding are protocol violations; ignore them so
  // the counter can never underflow.
  assign w_ret         = imem_rvalid_i & (r_outstanding != '0);
  assign w_has_discard = (r_discard != '0);
  assign w_push        = w_ret & ~w_has_discard & ~flush_i;

  assign w_not_empty   = (r_count != '0);
  assign inst_valid_o  = w_not_empty & ~flush_i;
  assign w_pop         = inst_valid_o & id_ready_i;
  assign pc_o          = w_not_empty ? r_fifo_pc[r_rd_ptr]   : 32'h0;
  assign inst_o        = w_not_empty ? r_fifo_inst[r_rd_ptr] : 32'h0;

  // Outstanding count once this cycle's return is accounted for; on a flush
  // this is exactly the number of stale responses still to arrive.
  assign w_out_after_ret = r_outstanding - c_CNT_W'(w_ret);
  assign w_flush_pc      = flush_pc_i & ~32'h3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_count       <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_pc[i]   <= '0;
        r_fifo_inst[i] <= '0;
      end
    end else begin
      // No request is made during a flush, so w_issue is 0 in that cycle.
      r_outstanding <= w_out_after_ret + c_CNT_W'(w_issue);
      if (flush_i) begin
        r_fetch_pc <= w_flush_pc;
        r_resp_pc  <= w_flush_pc;
        r_discard  <= w_out_after_ret;
        r_count    <= '0;
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
      end else begin
        if (w_issue) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (w_ret && w_has_discard) begin
          r_discard <= r_discard - 1'b1;
        end
        if (w_push) begin
          r_fifo_pc[r_wr_ptr]   <= r_resp_pc;
          r_fifo_inst[r_wr_ptr] <= imem_rdata_i;
          r_wr_ptr              <= r_wr_ptr + 1'b1;
          r_resp_pc             <= r_resp_pc + 32'd4;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
      end
    end
  end

endmodule
`default_nettype wire
